seq_comparator: RTL and testbench

Parametrised multi-cycle magnitude comparator for WIDTH-bit operands.

- Compares operands CHUNK bits per cycle, most-significant chunk first.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Uses a valid/ready handshake on both input and output.
- Serves datapaths where a full-width single-cycle compare would limit clock frequency.

---
 rtl/seq_comparator.sv | 139 +++++++++++++
 tb/tb_seq_comparator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_comparator.sv
// seq_comparator: multi-cycle magnitude comparator, CHUNK bits per cycle, most-significant chunk first.
// Optional macro CMP_EARLY_EXIT_EN: finish at the first differing chunk instead of after all NCHUNK chunks.
module seq_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a_gt_b,
    output logic             a_eq_b,
    output logic             a_lt_b,
    output logic             busy,
    output logic [1:0]       dbg_state_o
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both 1.
    // A producer holds valid and its payload until that edge; ready never depends on valid.
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("seq_comparator: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;

    logic [WIDTH-1:0] a_cmp, b_cmp;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] a_chunk, b_chunk;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_cmp = a_q;
        b_cmp = b_q;
        if (signed_q) begin
            a_cmp[WIDTH-1] = ~a_q[WIDTH-1];
            b_cmp[WIDTH-1] = ~b_q[WIDTH-1];
        end
        a_sh    = a_cmp >> (32'(idx_q) * CHUNK);
        b_sh    = b_cmp >> (32'(idx_q) * CHUNK);
        a_chunk = a_sh[CHUNK-1:0];
        b_chunk = b_sh[CHUNK-1:0];
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;

        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q != S_IDLE);
        a_gt_b    = out_valid & decided_q & gt_q;
        a_lt_b    = out_valid & decided_q & ~gt_q;
        a_eq_b    = out_valid & ~decided_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    signed_d  = signed_mode;
                    idx_d     = IDXW'(NCHUNK - 1);
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = S_CMP;
                end
            end
            S_CMP: begin
                // The first differing chunk from the top decides; later chunks are ignored.
                if (!decided_q && (a_chunk != b_chunk)) begin
                    decided_d = 1'b1;
                    gt_d      = (a_chunk > b_chunk);
`ifdef CMP_EARLY_EXIT_EN
                    state_d   = S_DONE;
`endif
                end
                if (idx_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
        end
    end

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: random and directed operations on a 16/4 instance, scoreboard-checked,
// plus a 8/8 instance for the single-chunk case.
module tb_seq_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;

    // 16-bit, 4-bit chunk instance
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        signed_mode = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic        a_gt_b, a_eq_b, a_lt_b, busy;
    logic [1:0]  dbg_state;

    // 8-bit, single-chunk instance
    logic        iv8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sm8 = 1'b0;
    logic        ov8;
    logic        or8 = 1'b1;
    logic        gt8, eq8, lt8, busy8;
    logic [1:0]  dbg_state8;

    logic        rand_rdy = 1'b0;
    logic        fixed_rdy = 1'b1;
    logic        rnd_bit = 1'b1;
    assign out_ready = rand_rdy ? rnd_bit : fixed_rdy;

    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [2:0] flags;
        int         lat;
        int         acc;
    } exp_t;
    exp_t exp_q[$];

    logic        mon_en = 1'b0;
    logic        in_res = 1'b0;
    int          first_cyc = 0;
    logic [2:0]  held = '0;

    seq_comparator #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    seq_comparator #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(in_ready8),
        .a(a8), .b(b8), .signed_mode(sm8), .out_valid(ov8),
        .out_ready(or8), .a_gt_b(gt8), .a_eq_b(eq8), .a_lt_b(lt8),
        .busy(busy8), .dbg_state_o(dbg_state8)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // ---------------- reference model ----------------
    // Flags ordered {gt, eq, lt}; operands interpreted as w-bit numbers.
    function automatic logic [2:0] ref_flags(input logic [15:0] av, input logic [15:0] bv,
                                             input logic sm, input int w);
        longint sa, sb;
        sa = longint'(av);
        sb = longint'(bv);
        if (sm && av[w-1]) sa = sa - (longint'(1) << w);
        if (sm && bv[w-1]) sb = sb - (longint'(1) << w);
        return {sa > sb, sa == sb, sa < sb};
    endfunction

    // Cycles from accept edge to out_valid for the 16/4 instance.
    function automatic int ref_lat(input logic [15:0] av, input logic [15:0] bv);
`ifdef CMP_EARLY_EXIT_EN
        logic [15:0] d;
        int msb;
        d = av ^ bv;
        if (d == 16'h0) return 4;
        msb = 0;
        for (int i = 0; i < 16; i++) if (d[i]) msb = i;
        return 4 - msb / 4;
`else
        return 4 + 0 * int'(av ^ bv);
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sm,
                         input bit push);
        int e;
        int guard;
        exp_t x;
        @(posedge clk);
        #1;
        a = av;
        b = bv;
        signed_mode = sm;
        in_valid = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            guard++;
            if (guard > 300) begin
                chk("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        e = cyc;
        if (push) begin
            x.flags = ref_flags(av, bv, sm, 16);
            x.lat   = ref_lat(av, bv);
            x.acc   = e;
            exp_q.push_back(x);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || in_res) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sm);
        int e;
        int guard;
        logic [2:0] exp;
        exp = ref_flags({8'h00, av}, {8'h00, bv}, sm, 8);
        @(posedge clk);
        #1;
        a8 = av;
        b8 = bv;
        sm8 = sm;
        iv8 = 1'b1;
        @(negedge clk);
        chk("dut8_in_ready", in_ready8, 1);
        e = cyc;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!ov8 && guard < 10);
        chk("dut8_latency", cyc - e - 1, 1);
        chk("dut8_flags", {gt8, eq8, lt8}, exp);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (!in_res) begin
                    in_res = 1'b1;
                    first_cyc = cyc;
                    held = {a_gt_b, a_eq_b, a_lt_b};
                end else begin
                    chk("done_flags_stable", {a_gt_b, a_eq_b, a_lt_b}, held);
                end
                chk("in_ready_in_done", in_ready, 0);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        exp_t x;
                        x = exp_q.pop_front();
                        chk("result_flags", {a_gt_b, a_eq_b, a_lt_b}, x.flags);
                        chk("result_latency", first_cyc - x.acc - 1, x.lat);
                    end
                    in_res = 1'b0;
                end
            end else begin
                chk("flags_zero_outside_done", {a_gt_b, a_eq_b, a_lt_b}, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] ra, rb;
        int guard;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_flags", {a_gt_b, a_eq_b, a_lt_b}, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready8", in_ready8, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Directed operations, consumer always ready
        fixed_rdy = 1'b1;
        do_op(16'h1234, 16'h1234, 1'b0, 1'b1);
        @(negedge clk);
        chk("busy_after_accept", busy, 1);
        do_op(16'h8000, 16'h7FFF, 1'b0, 1'b1);
        do_op(16'h8000, 16'h7FFF, 1'b1, 1'b1);
        do_op(16'hA000, 16'h1000, 1'b0, 1'b1);
        do_op(16'h0001, 16'h0000, 1'b0, 1'b1);
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b1);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        drain();

        // Consumer stalls 5 cycles in DONE while the producer toggles inputs
        fixed_rdy = 1'b0;
        do_op(16'h1234, 16'h5678, 1'b0, 1'b1);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!out_valid && guard < 20);
        chk("stall_reach_done", out_valid, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fixed_rdy = 1'b1;
        drain();

        // Reset pulse in the middle of CMP abandons the operation
        do_op(16'h9999, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midcmp_reset_in_ready", in_ready, 1);
        chk("midcmp_reset_out_valid", out_valid, 0);
        chk("midcmp_reset_busy", busy, 0);
        repeat (8) @(posedge clk);
        do_op(16'd3, 16'd5, 1'b0, 1'b1);
        drain();

        // Randomized operations with a randomly stalling consumer
        rand_rdy = 1'b1;
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
                2: rb = {ra[15:8], 8'($urandom)};
                default: rb = 16'($urandom);
            endcase
            do_op(ra, rb, 1'($urandom_range(0, 1)), 1'b1);
        end
        drain();
        rand_rdy = 1'b0;

        // Single-chunk instance
        op8(8'hFF, 8'h01, 1'b1);
        op8(8'hFF, 8'h01, 1'b0);
        op8(8'h80, 8'h7F, 1'b1);
        op8(8'h42, 8'h42, 1'b0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
